// File: rtl/dmem_responder64.sv
// Data-memory responder: 64-bit byte-addressable memory behind valid/ready request and response
// channels, with lane-selected loads/stores, sign/zero extension and programmable wait states.
module dmem_responder64 #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddr,
    input  logic [63:0] ReqWData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [63:0] RspData,
    output logic        RspError
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} stateType;

    stateType          state;
    logic [3:0]        waitCount;

    logic              latWrite;
    logic [1:0]        latSize;
    logic              latSigned;
    logic [IDX_W-1:0]  latWordIdx;
    logic [2:0]        latLane;
    logic [63:0]       latWData;

    logic [63:0]       mem [DEPTH_WORDS] = '{default: 64'd0};

    logic              accepted;
    logic              reqMisaligned;
    logic              reqOutOfRange;
    logic [5:0]        laneShift;
    logic [63:0]       accessWord;
    logic [63:0]       laneMask;
    logic [63:0]       mergedWord;
    logic [63:0]       loadData;

    function automatic logic [63:0] sizeMask(input logic [1:0] size);
        case (size)
            2'd0:    sizeMask = 64'h0000_0000_0000_00FF;
            2'd1:    sizeMask = 64'h0000_0000_0000_FFFF;
            2'd2:    sizeMask = 64'h0000_0000_FFFF_FFFF;
            default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            2'd0:    isMisaligned = 1'b0;
            2'd1:    isMisaligned = lane[0];
            2'd2:    isMisaligned = |lane[1:0];
            default: isMisaligned = |lane[2:0];
        endcase
    endfunction

    // raw holds the addressed lane shifted down to bit 0
    function automatic logic [63:0] extendLoad(input logic [63:0] raw, input logic [1:0] size,
                                               input logic sgn);
        case (size)
            2'd0:    extendLoad = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    extendLoad = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    extendLoad = {{32{sgn & raw[31]}}, raw[31:0]};
            default: extendLoad = raw;
        endcase
    endfunction

    assign ReqReady      = (state == IDLE) && !Reset;
    assign accepted      = ReqValid && ReqReady;
    assign reqMisaligned = isMisaligned(ReqSize, ReqAddr[2:0]);
    assign reqOutOfRange = ReqAddr[63:3] >= 61'(DEPTH_WORDS);

    assign laneShift  = {latLane, 3'b000};
    assign accessWord = mem[latWordIdx];
    assign laneMask   = sizeMask(latSize) << laneShift;
    assign mergedWord = (accessWord & ~laneMask) | ((latWData & sizeMask(latSize)) << laneShift);
    assign loadData   = extendLoad(accessWord >> laneShift, latSize, latSigned);

    // Request capture holds only data; control qualification comes from the FSM
    always_ff @(posedge Clk) begin
        if (accepted) begin
            latWrite   <= ReqWrite;
            latSize    <= ReqSize;
            latSigned  <= ReqSigned;
            latWordIdx <= ReqAddr[IDX_W+2:3];
            latLane    <= ReqAddr[2:0];
            latWData   <= ReqWData;
        end
    end

    // Memory is deliberately outside the reset domain; an async reset moves state out of
    // ACCESS before the next edge, so an aborted store never reaches this write
    always_ff @(posedge Clk) begin
        if (state == ACCESS && latWrite) begin
            mem[latWordIdx] <= mergedWord;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            RspValid  <= 1'b0;
            RspData   <= 64'd0;
            RspError  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accepted) begin
                        if (reqMisaligned || reqOutOfRange) begin
                            state    <= RESP;
                            RspValid <= 1'b1;
                            RspError <= 1'b1;
                            RspData  <= 64'd0;
                        end else if (WAIT_STATES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state     <= WAIT;
                            waitCount <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (waitCount == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        waitCount <= waitCount - 4'd1;
                    end
                end
                ACCESS: begin
                    state    <= RESP;
                    RspValid <= 1'b1;
                    RspError <= 1'b0;
                    RspData  <= latWrite ? 64'd0 : loadData;
                end
                RESP: begin
                    if (RspReady) begin
                        state    <= IDLE;
                        RspValid <= 1'b0;
                        RspData  <= 64'd0;
                        RspError <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
